// File: rtl/stack_cpu_pkg.sv
// Shared definitions for the stack CPU control sequencer: opcodes, FSM state
// encoding, ALU operation selects and trap codes.
package stack_cpu_pkg;

  localparam logic [5:0] OpNop  = 6'd0;
  localparam logic [5:0] OpPush = 6'd1;
  localparam logic [5:0] OpPop  = 6'd2;
  localparam logic [5:0] OpAdd  = 6'd3;
  localparam logic [5:0] OpSub  = 6'd4;
  localparam logic [5:0] OpDup  = 6'd5;
  localparam logic [5:0] OpJmp  = 6'd6;
  localparam logic [5:0] OpJz   = 6'd7;
  localparam logic [5:0] OpHalt = 6'd63;

  typedef enum logic [2:0] {
    StFetch,
    StLoad,
    StDecode,
    StPopB,
    StPopA,
    StExec,
    StHalt,
    StError
  } state_e;

  localparam logic [1:0] AluAdd   = 2'b00;
  localparam logic [1:0] AluSub   = 2'b01;
  localparam logic [1:0] AluPassA = 2'b10;

  localparam logic [1:0] ErrNone    = 2'b00;
  localparam logic [1:0] ErrUnder   = 2'b01;
  localparam logic [1:0] ErrOver    = 2'b10;
  localparam logic [1:0] ErrIllegal = 2'b11;

endpackage

// File: rtl/stack_cpu_ctrl.sv
// Multi-cycle control sequencer for the stack CPU.
// Fetches instruction words, decodes IR[31:26], sequences operand pops, the ALU
// and result pushes, tracks stack depth and traps on under/overflow and illegal
// opcodes.
// Ports:
//   clk_i, rst_ni                 clock, asynchronous active-low reset
//   imem_addr_o/imem_en_o/imem_data_i   instruction fetch (1-cycle read latency)
//   stk_push_o/stk_pop_o/stk_wdata_o/stk_tos_i   operand stack RAM interface
//   alu_op_o/alu_a_o/alu_b_o/alu_y_i     ALU interface (result combinational)
//   pc_o, depth_o, halted_o, error_o, err_code_o, retired_o   status
module stack_cpu_ctrl
  import stack_cpu_pkg::*;
#(
  parameter int unsigned DataW = 32,
  parameter int unsigned AddrW = 7,
  parameter int unsigned Depth = 16,
  localparam int unsigned DepthW = $clog2(Depth + 1)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  output logic [AddrW-1:0]  imem_addr_o,
  output logic              imem_en_o,
  input  logic [31:0]       imem_data_i,
  output logic              stk_push_o,
  output logic              stk_pop_o,
  output logic [DataW-1:0]  stk_wdata_o,
  input  logic [DataW-1:0]  stk_tos_i,
  output logic [1:0]        alu_op_o,
  output logic [DataW-1:0]  alu_a_o,
  output logic [DataW-1:0]  alu_b_o,
  input  logic [DataW-1:0]  alu_y_i,
  output logic [AddrW-1:0]  pc_o,
  output logic [DepthW-1:0] depth_o,
  output logic              halted_o,
  output logic              error_o,
  output logic [1:0]        err_code_o,
  output logic [31:0]       retired_o
);

  state_e            state_q, state_d;
  logic [AddrW-1:0]  pc_q, pc_d;
  logic [DepthW-1:0] depth_q, depth_d;
  logic [DataW-1:0]  a_q, a_d, b_q, b_d;
  logic [31:0]       ir_q, ir_d;
  logic              halted_q, halted_d, error_q, error_d;
  logic [1:0]        err_code_q, err_code_d;
  logic [31:0]       retired_q, retired_d;

  logic [5:0]        opcode;
  logic [DataW-1:0]  imm_sext;
  logic [AddrW-1:0]  target;
  logic              legal, need2, need1, grows;
  logic              unused_ir;

  assign opcode    = ir_q[31:26];
  assign imm_sext  = {{(DataW-16){ir_q[15]}}, ir_q[15:0]};
  assign target    = ir_q[AddrW-1:0];
  assign unused_ir = ^ir_q[25:16];

  // Stack requirements of the decoded opcode.
  always_comb begin
    legal = 1'b1;
    need2 = 1'b0;
    need1 = 1'b0;
    grows = 1'b0;
    case (opcode)
      OpNop, OpJmp, OpHalt: ;
      OpPush:               grows = 1'b1;
      OpPop, OpJz:          need1 = 1'b1;
      OpAdd, OpSub:         need2 = 1'b1;
      OpDup: begin
        need1 = 1'b1;
        grows = 1'b1;
      end
      default:              legal = 1'b0;
    endcase
  end

  always_comb begin
    case (opcode)
      OpAdd:   alu_op_o = AluAdd;
      OpSub:   alu_op_o = AluSub;
      default: alu_op_o = AluPassA;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    depth_d     = depth_q;
    a_d         = a_q;
    b_d         = b_q;
    ir_d        = ir_q;
    halted_d    = halted_q;
    error_d     = error_q;
    err_code_d  = err_code_q;
    retired_d   = retired_q;
    imem_en_o   = 1'b0;
    stk_push_o  = 1'b0;
    stk_pop_o   = 1'b0;
    stk_wdata_o = '0;

    case (state_q)
      StFetch: begin
        imem_en_o = 1'b1;
        state_d   = StLoad;
      end
      StLoad: begin
        ir_d    = imem_data_i;
        state_d = StDecode;
      end
      StDecode: begin
        // Trap priority: illegal, then underflow, then overflow.
        if (!legal) begin
          state_d    = StError;
          error_d    = 1'b1;
          err_code_d = ErrIllegal;
        end else if ((need2 && depth_q < DepthW'(2)) || (need1 && depth_q == '0)) begin
          state_d    = StError;
          error_d    = 1'b1;
          err_code_d = ErrUnder;
        end else if (grows && depth_q == DepthW'(Depth)) begin
          state_d    = StError;
          error_d    = 1'b1;
          err_code_d = ErrOver;
        end else begin
          state_d = need2 ? StPopB : StExec;
        end
      end
      StPopB: begin
        b_d       = stk_tos_i;
        stk_pop_o = 1'b1;
        depth_d   = depth_q - DepthW'(1);
        state_d   = StPopA;
      end
      StPopA: begin
        a_d       = stk_tos_i;
        stk_pop_o = 1'b1;
        depth_d   = depth_q - DepthW'(1);
        state_d   = StExec;
      end
      StExec: begin
        retired_d = retired_q + 32'd1;
        pc_d      = pc_q + AddrW'(1);
        state_d   = StFetch;
        case (opcode)
          OpPush: begin
            stk_push_o  = 1'b1;
            stk_wdata_o = imm_sext;
            depth_d     = depth_q + DepthW'(1);
          end
          OpDup: begin
            stk_push_o  = 1'b1;
            stk_wdata_o = stk_tos_i;
            depth_d     = depth_q + DepthW'(1);
          end
          OpAdd, OpSub: begin
            stk_push_o  = 1'b1;
            stk_wdata_o = alu_y_i;
            depth_d     = depth_q + DepthW'(1);
          end
          OpPop: begin
            stk_pop_o = 1'b1;
            depth_d   = depth_q - DepthW'(1);
          end
          OpJz: begin
            stk_pop_o = 1'b1;
            depth_d   = depth_q - DepthW'(1);
            if (stk_tos_i == '0) pc_d = target;
          end
          OpJmp:   pc_d = target;
          OpHalt: begin
            pc_d     = pc_q;
            halted_d = 1'b1;
            state_d  = StHalt;
          end
          default: ;
        endcase
      end
      StHalt, StError: ;
      default: state_d = StError;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StFetch;
      pc_q       <= '0;
      depth_q    <= '0;
      a_q        <= '0;
      b_q        <= '0;
      ir_q       <= '0;
      halted_q   <= 1'b0;
      error_q    <= 1'b0;
      err_code_q <= ErrNone;
      retired_q  <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      depth_q    <= depth_d;
      a_q        <= a_d;
      b_q        <= b_d;
      ir_q       <= ir_d;
      halted_q   <= halted_d;
      error_q    <= error_d;
      err_code_q <= err_code_d;
      retired_q  <= retired_d;
    end
  end

  assign imem_addr_o = pc_q;
  assign pc_o        = pc_q;
  assign depth_o     = depth_q;
  assign alu_a_o     = a_q;
  assign alu_b_o     = b_q;
  assign halted_o    = halted_q;
  assign error_o     = error_q;
  assign err_code_o  = err_code_q;
  assign retired_o   = retired_q;

endmodule

// File: tb/tb_stack_cpu_ctrl.sv
// Bench for stack_cpu_ctrl: instruction memory, stack RAM and ALU models around
// the DUT, a program-level interpreter producing the expected stack event
// stream and final status, and a monitor that scores every push/pop.
module tb_stack_cpu_ctrl;

  localparam int DW = 32;
  localparam int AW = 7;

  logic          clk, rst_n;
  logic [AW-1:0] imem_addr;
  logic          imem_en;
  logic [31:0]   imem_data;
  logic          stk_push, stk_pop;
  logic [DW-1:0] stk_wdata, stk_tos;
  logic [1:0]    alu_op;
  logic [DW-1:0] alu_a, alu_b, alu_y;
  logic [AW-1:0] pc;
  logic [4:0]    depth;
  logic          halted, error;
  logic [1:0]    err_code;
  logic [31:0]   retired;

  stack_cpu_ctrl dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .imem_addr_o(imem_addr),
    .imem_en_o  (imem_en),
    .imem_data_i(imem_data),
    .stk_push_o (stk_push),
    .stk_pop_o  (stk_pop),
    .stk_wdata_o(stk_wdata),
    .stk_tos_i  (stk_tos),
    .alu_op_o   (alu_op),
    .alu_a_o    (alu_a),
    .alu_b_o    (alu_b),
    .alu_y_i    (alu_y),
    .pc_o       (pc),
    .depth_o    (depth),
    .halted_o   (halted),
    .error_o    (error),
    .err_code_o (err_code),
    .retired_o  (retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Environment: instruction ROM, stack RAM, ALU.
  logic [31:0] imem [128];
  always @(posedge clk) if (imem_en) imem_data <= imem[imem_addr];

  logic [31:0] smem [16];
  logic [4:0]  sp;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) sp <= '0;
    else if (stk_push && sp < 5'd16) begin
      smem[sp[3:0]] <= stk_wdata;
      sp <= sp + 5'd1;
    end else if (stk_pop && sp > 5'd0) sp <= sp - 5'd1;
  end
  assign stk_tos = (sp > 5'd0) ? smem[sp[3:0] - 4'd1] : '0;
  assign alu_y = (alu_op == 2'b00) ? alu_a + alu_b : (alu_op == 2'b01) ? alu_a - alu_b : alu_a;

  // Scoreboard
  typedef struct packed {
    logic        is_push;
    logic [31:0] data;
  } ev_t;
  ev_t exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic ev_t mk(input logic p, input logic [31:0] d);
    ev_t e;
    e.is_push = p;
    e.data    = d;
    return e;
  endfunction

  always @(negedge clk) begin
    if (rst_n && (stk_push || stk_pop)) begin
      if (stk_push && stk_pop) check("push_pop_exclusive", 32'(stk_push & stk_pop), 32'd0);
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_stack_access: got push=%0b pop=%0b expected none",
                 stk_push, stk_pop);
      end else begin
        ev_t e;
        e = exp_q.pop_front();
        check("stack_op_kind", 32'(stk_push), 32'(e.is_push));
        if (stk_push) check("push_data", stk_wdata, e.data);
      end
    end
  end

  // Reference interpreter
  int          exp_pc, exp_depth, exp_ret, exp_cycles;
  logic        exp_halt, exp_err;
  logic [1:0]  exp_code;

  task automatic model_run();
    logic [31:0] st[$];
    logic [31:0] w, imm, a, b;
    int p, steps;
    logic done;
    p = 0; steps = 0; done = 0;
    exp_ret = 0; exp_halt = 0; exp_err = 0; exp_code = 2'b00;
    while (!done && steps < 3000) begin
      w = imem[p];
      imm = {{16{w[15]}}, w[15:0]};
      steps++;
      case (int'(w[31:26]))
        0: begin p = (p + 1) % 128; exp_ret++; end
        1: if (st.size() >= 16) exp_code = 2'b10;
           else begin st.push_back(imm); exp_q.push_back(mk(1, imm)); p = (p + 1) % 128; exp_ret++; end
        2: if (st.size() < 1) exp_code = 2'b01;
           else begin void'(st.pop_back()); exp_q.push_back(mk(0, 0)); p = (p + 1) % 128; exp_ret++; end
        3, 4: if (st.size() < 2) exp_code = 2'b01;
           else begin
             b = st.pop_back(); a = st.pop_back();
             if (w[31:26] == 6'd3) a = a + b; else a = a - b;
             st.push_back(a);
             exp_q.push_back(mk(0, 0)); exp_q.push_back(mk(0, 0)); exp_q.push_back(mk(1, a));
             p = (p + 1) % 128; exp_ret++;
           end
        5: if (st.size() < 1) exp_code = 2'b01;
           else if (st.size() >= 16) exp_code = 2'b10;
           else begin
             a = st[st.size() - 1]; st.push_back(a); exp_q.push_back(mk(1, a));
             p = (p + 1) % 128; exp_ret++;
           end
        6: begin p = int'(w[6:0]); exp_ret++; end
        7: if (st.size() < 1) exp_code = 2'b01;
           else begin
             a = st.pop_back(); exp_q.push_back(mk(0, 0));
             p = (a == 0) ? int'(w[6:0]) : (p + 1) % 128; exp_ret++;
           end
        63: begin exp_ret++; exp_halt = 1; done = 1; end
        default: exp_code = 2'b11;
      endcase
      if (exp_code != 2'b00) begin exp_err = 1; done = 1; end
    end
    exp_pc = p;
    exp_depth = st.size();
    exp_cycles = steps * 7 + 50;
  endtask

  function automatic logic [31:0] ins(input logic [5:0] op, input logic [15:0] imm);
    return {op, 10'd0, imm};
  endfunction

  task automatic clear_mem();
    for (int i = 0; i < 128; i++) imem[i] = ins(6'd63, 16'd0);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "/pc"}, 32'(pc), 32'd0);
    check({tag, "/depth"}, 32'(depth), 32'd0);
    check({tag, "/push"}, 32'(stk_push), 32'd0);
    check({tag, "/pop"}, 32'(stk_pop), 32'd0);
    check({tag, "/alu_a"}, alu_a, 32'd0);
    check({tag, "/alu_b"}, alu_b, 32'd0);
    check({tag, "/halted"}, 32'(halted), 32'd0);
    check({tag, "/error"}, 32'(error), 32'd0);
    check({tag, "/err_code"}, 32'(err_code), 32'd0);
    check({tag, "/retired"}, retired, 32'd0);
  endtask

  // Holds reset, loads expectations from the model, then releases.
  task automatic start_prog();
    @(negedge clk);
    rst_n = 1'b0;
    exp_q.delete();
    model_run();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run_prog(input string name);
    int cyc;
    start_prog();
    cyc = 0;
    while (!(halted || error) && cyc < exp_cycles) begin
      @(negedge clk);
      cyc++;
    end
    if (!(halted || error)) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s/timeout: got running after %0d cycles expected halt or trap", name, cyc);
    end
    repeat (3) @(negedge clk);
    check({name, "/events_left"}, 32'(exp_q.size()), 32'd0);
    check({name, "/pc"}, 32'(pc), 32'(exp_pc));
    check({name, "/depth"}, 32'(depth), 32'(exp_depth));
    check({name, "/halted"}, 32'(halted), 32'(exp_halt));
    check({name, "/error"}, 32'(error), 32'(exp_err));
    check({name, "/err_code"}, 32'(err_code), 32'(exp_code));
    check({name, "/retired"}, retired, 32'(exp_ret));
  endtask

  initial begin
    int cyc, len, r, tgt;
    rst_n = 1'b1;
    clear_mem();
    #3 rst_n = 1'b0;
    #1 check_reset_values("por");

    clear_mem();
    imem[0] = ins(1, 5); imem[1] = ins(1, 3); imem[2] = ins(3, 0); imem[3] = ins(63, 0);
    run_prog("add_halt");

    clear_mem();
    imem[0] = ins(1, 3); imem[1] = ins(1, 5); imem[2] = ins(4, 0);
    run_prog("sub_neg");

    clear_mem();
    imem[0] = ins(1, 1); imem[1] = ins(3, 0);
    run_prog("add_underflow");

    clear_mem();
    for (int i = 0; i < 17; i++) imem[i] = ins(1, 1);
    run_prog("push_overflow");

    clear_mem();
    imem[0] = ins(1, 0); imem[1] = ins(7, 10);
    run_prog("jz_taken");

    clear_mem();
    imem[0] = ins(1, 7); imem[1] = ins(7, 10); imem[2] = ins(0, 0);
    run_prog("jz_not_taken");

    clear_mem();
    imem[0] = ins(6'h3E, 0);
    run_prog("illegal");

    clear_mem();
    imem[0] = ins(5, 0);
    run_prog("dup_empty");

    // pc wrap 127 -> 0; stack grows each lap until overflow trap
    clear_mem();
    imem[0] = ins(1, 0); imem[1] = ins(7, 127); imem[127] = ins(1, 16'hFFFF);
    run_prog("pc_wrap");

    // Reset in the middle of an ADD, during the second pop
    clear_mem();
    imem[0] = ins(1, 5); imem[1] = ins(1, 3); imem[2] = ins(3, 0); imem[3] = ins(63, 0);
    start_prog();
    cyc = 0;
    while (!stk_pop && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check("midreset/pop_b_seen", 32'(stk_pop), 32'd1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset_values("midreset");
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("midreset/push_after_release", 32'(stk_push), 32'd0);
    check("midreset/pop_after_release", 32'(stk_pop), 32'd0);
    run_prog("after_midreset");

    // Random programs with forward-only control flow
    for (int t = 0; t < 10; t++) begin
      clear_mem();
      len = 24;
      for (int i = 0; i < len; i++) begin
        r = $urandom_range(0, 20);
        tgt = i + 1 + $urandom_range(0, 3);
        if (r < 2)       imem[i] = ins(0, 16'($urandom));
        else if (r < 9)  imem[i] = ins(1, 16'($urandom));
        else if (r < 11) imem[i] = ins(2, 0);
        else if (r < 13) imem[i] = ins(3, 0);
        else if (r < 15) imem[i] = ins(4, 0);
        else if (r < 17) imem[i] = ins(5, 0);
        else if (r < 18) imem[i] = ins(7, 16'(tgt));
        else if (r < 19) imem[i] = ins(6, 16'(tgt));
        else if (r < 20) imem[i] = ins(1, 16'd0);
        else             imem[i] = ins(6'($urandom_range(8, 62)), 0);
      end
      run_prog($sformatf("rand%0d", t));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
